// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for pipeline sequencing: FSM states, stage-control modes
// and the decode from a mode to the individual register controls.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        RESUME = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_STALL  = 2'd1,
        MODE_FLUSH  = 2'd2,
        MODE_FREEZE = 2'd3
    } mode_t;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic pc_en;
        logic if_id_lock;
        logic if_id_clear;
        logic id_ex_lock;
        logic id_ex_clear;
        logic ex_mem_lock;
        logic mem_wb_lock;
    } stage_ctrl_t;

    function automatic stage_ctrl_t decode_mode(input mode_t mode);
        stage_ctrl_t c;
        c = '0;
        case (mode)
            MODE_NORMAL: c = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            MODE_STALL:  c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            MODE_FLUSH:  c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             lu
);

    // Register zero is hardwired, so a load targeting it never creates a dependency.
    assign lu = ex_mem_read && (ex_rd != REG_W'(REG_ZERO)) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stage-register enables/flushes, halt/resume FSM
// and performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    input  logic             wb_halt,
    input  logic             go,
    output logic             pc_en,
    output logic             if_id_lock,
    output logic             if_id_clear,
    output logic             id_ex_lock,
    output logic             id_ex_clear,
    output logic             ex_mem_lock,
    output logic             mem_wb_lock,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t      state_reg;
    mode_t       mode;
    stage_ctrl_t ctrl;
    logic        lu;

    load_use_detect #(.REG_W(REG_W)) u_lu (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .lu          (lu)
    );

    // RESUME decodes like RUN but lets the retiring halt leave WB.
    always_comb begin
        mode = MODE_FREEZE;
        if (!reset) begin
            case (state_reg)
                RUN, RESUME: begin
                    if (wb_halt && state_reg == RUN) mode = MODE_FREEZE;
                    else if (ex_redirect)            mode = MODE_FLUSH;
                    else if (lu)                     mode = MODE_STALL;
                    else                             mode = MODE_NORMAL;
                end
                default: mode = MODE_FREEZE;
            endcase
        end
    end

    assign ctrl        = decode_mode(mode);
    assign pc_en       = ctrl.pc_en;
    assign if_id_lock  = ctrl.if_id_lock;
    assign if_id_clear = ctrl.if_id_clear;
    assign id_ex_lock  = ctrl.id_ex_lock;
    assign id_ex_clear = ctrl.id_ex_clear;
    assign ex_mem_lock = ctrl.ex_mem_lock;
    assign mem_wb_lock = ctrl.mem_wb_lock;
    assign halted      = !reset && (state_reg == HALTED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (wb_halt) state_reg <= HALTED;
                end
                HALTED: begin
                    if (go) state_reg <= RESUME;
                end
                default: state_reg <= RUN;
            endcase
            if (state_reg == RUN || state_reg == RESUME) cycle_cnt <= cycle_cnt + 1'b1;
            if (mode == MODE_STALL) stall_cnt <= stall_cnt + 1'b1;
            if (mode == MODE_FLUSH) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
